fpadd_pipe: RTL

Parametrised, four-stage pipelined floating-point adder/subtractor: the next generation of the team's single-cycle FP32 adder. It adds configurable exponent/mantissa widths, a per-operation add/sub select, selectable truncate or round-to-nearest-even rounding, valid tracking and a clock-enable stall. It sits in the FPU datapath between the operand registers and the result writeback.

---
 rtl/fpadd_pipe_if.sv | 27 ++
 rtl/fpadd_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpadd_pipe_if.sv
// Operand/result bundle for fpadd_pipe: clock enable, operands, op controls and result.
// The master drives operands; the slave (the adder) returns the result.
interface fpadd_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         ce;
    logic         in_valid;
    logic [W-1:0] reg_A;
    logic [W-1:0] reg_B;
    logic         op_sub;
    logic         rnd_rne;
    logic         out_valid;
    logic [W-1:0] out;

    modport master (
        output ce, in_valid, reg_A, reg_B, op_sub, rnd_rne,
        input  out_valid, out
    );

    modport slave (
        input  ce, in_valid, reg_A, reg_B, op_sub, rnd_rne,
        output out_valid, out
    );
endinterface

// File: rtl/fpadd_pipe.sv
// Four-stage pipelined FP add/sub (unpack, align/add, normalize, round/pack) with ce stall.
// Define FPADD_SPECIAL_EN to decode inf/NaN and saturate exponent over/underflow.
module fpadd_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic         clk,
    input logic         reset_n,
    fpadd_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int AW = MAN_W + 3;   // {hidden, man, G, R}
    localparam int NW = MAN_W + 4;   // {hidden, man, G, R, S}
    localparam int SW = MAN_W + 5;   // NW plus carry
`ifdef FPADD_SPECIAL_EN
    localparam int EXW = EXP_W + 2;  // room for sign and overflow detection
    localparam logic [EXW-1:0] EXP_ONES = EXW'({EXP_W{1'b1}});
    localparam logic [EXW-1:0] EXP_ZERO = '0;
`else
    localparam int EXW = EXP_W;      // wraps modulo 2^EXP_W
`endif

    typedef struct packed {
        logic         valid;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         rne;
    } in_t;

    typedef struct packed {
        logic             valid;
        logic             rne;
        logic             eff_sub;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man_big;
        logic [MAN_W-1:0] man_small;
        logic [EXP_W-1:0] d;
        logic             byp;
        logic [W-1:0]     byp_val;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic             rne;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SW-1:0]    sum;
        logic             byp;
        logic [W-1:0]     byp_val;
    } s2_t;

    typedef struct packed {
        logic           valid;
        logic           rne;
        logic           sign;
        logic [EXW-1:0] exp;
        logic [NW-2:0]  frac;   // normalized, hidden bit dropped
        logic           zero;
        logic           byp;
        logic [W-1:0]   byp_val;
    } s3_t;

    in_t          in_q, in_d;
    s1_t          s1_q, s1_d;
    s2_t          s2_q, s2_d;
    s3_t          s3_q, s3_d;
    logic [W-1:0] out_q, out_d;
    logic         out_valid_q, out_valid_d;

    // S0: operand capture
    always_comb begin
        in_d       = '0;
        in_d.valid = bus.in_valid;
        in_d.a     = bus.reg_A;
        in_d.b     = bus.reg_B;
        in_d.sub   = bus.op_sub;
        in_d.rne   = bus.rnd_rne;
    end

    // S1: unpack, effective signs, magnitude swap
    logic             sa, sb, a_zero, b_zero, swap;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
`ifdef FPADD_SPECIAL_EN
    logic             a_nan, b_nan, a_inf, b_inf;
`endif

    always_comb begin
        s1_d   = '0;
        sa     = in_q.a[W-1];
        sb     = in_q.b[W-1] ^ in_q.sub;
        ea     = in_q.a[W-2 -: EXP_W];
        eb     = in_q.b[W-2 -: EXP_W];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        ma     = a_zero ? '0 : in_q.a[MAN_W-1:0];
        mb     = b_zero ? '0 : in_q.b[MAN_W-1:0];
        swap   = {eb, mb} > {ea, ma};

        s1_d.valid     = in_q.valid;
        s1_d.rne       = in_q.rne;
        s1_d.eff_sub   = sa ^ sb;
        s1_d.sign      = swap ? sb : sa;
        s1_d.exp       = swap ? eb : ea;
        s1_d.man_big   = swap ? mb : ma;
        s1_d.man_small = swap ? ma : mb;
        s1_d.d         = swap ? (eb - ea) : (ea - eb);

        if (a_zero && b_zero) begin
            s1_d.byp     = 1'b1;
            s1_d.byp_val = {sa & sb, {(W-1){1'b0}}};
        end else if (a_zero || b_zero) begin
            s1_d.byp     = 1'b1;
            s1_d.byp_val = {s1_d.sign, s1_d.exp, s1_d.man_big};
        end
`ifdef FPADD_SPECIAL_EN
        a_nan = (ea == '1) && (ma != '0);
        b_nan = (eb == '1) && (mb != '0);
        a_inf = (ea == '1) && (ma == '0);
        b_inf = (eb == '1) && (mb == '0);
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            s1_d.byp     = 1'b1;
            s1_d.byp_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (a_inf) begin
            s1_d.byp     = 1'b1;
            s1_d.byp_val = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            s1_d.byp     = 1'b1;
            s1_d.byp_val = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
`endif
    end

    // S2: align small operand with G/R/S, then add or subtract
    logic [2*AW-1:0] wide;
    logic [AW-1:0]   al;
    logic            st;
    logic [NW-1:0]   big_v, small_v;

    always_comb begin
        s2_d = '0;
        wide = '0;
        al   = '0;
        st   = 1'b0;
        if (int'(s1_q.d) >= AW) begin
            st = 1'b1;
        end else begin
            wide = {1'b1, s1_q.man_small, 2'b00, {AW{1'b0}}} >> s1_q.d;
            al   = wide[2*AW-1:AW];
            st   = |wide[AW-1:0];
        end
        big_v   = {1'b1, s1_q.man_big, 3'b000};
        small_v = {al, st};

        s2_d.valid   = s1_q.valid;
        s2_d.rne     = s1_q.rne;
        s2_d.sign    = s1_q.sign;
        s2_d.exp     = s1_q.exp;
        s2_d.sum     = s1_q.eff_sub ? ({1'b0, big_v} - {1'b0, small_v})
                                    : ({1'b0, big_v} + {1'b0, small_v});
        s2_d.byp     = s1_q.byp;
        s2_d.byp_val = s1_q.byp_val;
    end

    // S3: normalize
    logic [EXW-1:0] lzc;

    always_comb begin
        s3_d = '0;
        lzc  = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            if (s2_q.sum[i]) lzc = EXW'(NW - 1 - i);
        end
        if (s2_q.sum[SW-1]) begin
            s3_d.frac = {s2_q.sum[SW-2:2], s2_q.sum[1] | s2_q.sum[0]};
            s3_d.exp  = EXW'(s2_q.exp) + EXW'(1);
        end else begin
            s3_d.frac = s2_q.sum[NW-2:0] << lzc;
            s3_d.exp  = EXW'(s2_q.exp) - lzc;
        end
        s3_d.valid   = s2_q.valid;
        s3_d.rne     = s2_q.rne;
        s3_d.sign    = s2_q.sign;
        s3_d.zero    = (s2_q.sum == '0);
        s3_d.byp     = s2_q.byp;
        s3_d.byp_val = s2_q.byp_val;
    end

    // S4: round and pack
    logic           inc;
    logic [MAN_W:0] man_r;
    logic [EXW-1:0] exp_r;
    logic [W-1:0]   res;

    always_comb begin
        inc   = s3_q.rne & s3_q.frac[2] & (s3_q.frac[1] | s3_q.frac[0] | s3_q.frac[3]);
        man_r = {1'b0, s3_q.frac[NW-2:3]} + (MAN_W+1)'(inc);
        exp_r = s3_q.exp + EXW'(man_r[MAN_W]);
        res   = {s3_q.sign, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
`ifdef FPADD_SPECIAL_EN
        if ($signed(exp_r) >= $signed(EXP_ONES)) begin
            res = {s3_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if ($signed(exp_r) <= $signed(EXP_ZERO)) begin
            res = {s3_q.sign, {(W-1){1'b0}}};
        end
`endif
        if (s3_q.zero) res = '0;
        if (s3_q.byp)  res = s3_q.byp_val;

        out_d       = s3_q.valid ? res : out_q;
        out_valid_d = s3_q.valid;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q        <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.ce) begin
            in_q        <= in_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            s3_q        <= s3_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
endmodule
